// File: rtl/riscv_mem_pkg.sv
// Shared memory-path definitions: responder FSM encoding, request record and
// wait-state limits, reused by the core's stall logic.
package riscv_mem_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: loads on acceptance, counts down while waiting, and
// saturates at zero.
module mem_wait_counter
  import riscv_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && !zero)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);
  // Final wait edge: the decrement taking the count to zero commits the access.
  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory target: one outstanding lw/sw behind valid/ready,
// LATENCY wait states, misaligned/out-of-range accesses reported via resp_err.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int               IDX_W  = $clog2(DEPTH);
  localparam int               OFF_W  = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LATENCY);

  mem_state_e        state, state_nxt;
  mem_req_t          req_in, req_q, acc;
  logic [31:0]       mem [DEPTH];
  logic              accept, do_acc, acc_err, acc_wr;
  logic              cnt_zero, cnt_last;
  logic [IDX_W-1:0]  acc_idx;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_ready && req_valid;

  always_comb begin
    req_in       = '0;
    req_in.we    = req_we;
    req_in.addr  = req_addr;
    req_in.wdata = req_wdata;
  end

  // With zero wait states the access uses the request straight off the bus.
  assign acc     = (state == ST_IDLE) ? req_in : req_q;
  assign do_acc  = (accept && (LATENCY == 0)) ||
                   ((state == ST_WAIT) && (cnt_last || cnt_zero));
  assign acc_err = (|acc.addr[OFF_W-1:0]) || (|acc.addr[31:IDX_W+OFF_W]);
  assign acc_idx = acc.addr[IDX_W+OFF_W-1:OFF_W];
  assign acc_wr  = do_acc && acc.we && !acc_err && !reset;

  mem_wait_counter u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (LAT_LD),
    .dec      (state == ST_WAIT),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_last || cnt_zero) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept)
      req_q <= req_in;
  end

  // Storage is never cleared by reset.
  always_ff @(posedge clk) begin
    if (acc_wr)
      mem[acc_idx] <= acc.wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (do_acc) begin
      resp_valid <= 1'b1;
      resp_err   <= acc_err;
      resp_rdata <= (!acc_err && !acc.we) ? mem[acc_idx] : '0;
    end else if ((state == ST_RESP) && resp_ready) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 2, 0 and 1: vector table
// plus hand sequences for RESP hold, reset-on-commit and back-to-back spacing.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        resp_valid[3];
  logic        resp_ready[3];
  logic [31:0] resp_rdata[3];
  logic        resp_err  [3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction; lat = edges after acceptance until resp_valid is seen.
  task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata[d];
    er = resp_err[d];
    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc_c [$];
    int          waited;

    vt[0]  = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 2};
    vt[1]  = '{0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2};
    vt[2]  = '{0, 1'b1, 32'h0,        32'h11111111, 32'h0,        1'b0, 2};
    vt[3]  = '{0, 1'b1, 32'h13,       32'hFFFFFFFF, 32'h0,        1'b1, 2};
    vt[4]  = '{0, 1'b1, 32'h400,      32'hFFFFFFFF, 32'h0,        1'b1, 2};
    vt[5]  = '{0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2};
    vt[6]  = '{0, 1'b0, 32'h0,        32'h0,        32'h11111111, 1'b0, 2};
    vt[7]  = '{0, 1'b1, 32'h3FC,      32'hCAFEF00D, 32'h0,        1'b0, 2};
    vt[8]  = '{0, 1'b0, 32'h3FC,      32'h0,        32'hCAFEF00D, 1'b0, 2};
    vt[9]  = '{0, 1'b0, 32'h80000010, 32'h0,        32'h0,        1'b1, 2};
    vt[10] = '{0, 1'b1, 32'h20,       32'hA5A5A5A5, 32'h0,        1'b0, 2};
    vt[11] = '{1, 1'b1, 32'h0,        32'h00000005, 32'h0,        1'b0, 0};
    vt[12] = '{1, 1'b0, 32'h0,        32'h0,        32'h00000005, 1'b0, 0};
    vt[13] = '{1, 1'b1, 32'h13,       32'h77777777, 32'h0,        1'b1, 0};
    vt[14] = '{1, 1'b0, 32'h400,      32'h0,        32'h0,        1'b1, 0};
    vt[15] = '{1, 1'b0, 32'h0,        32'h0,        32'h00000005, 1'b0, 0};
    vt[16] = '{2, 1'b1, 32'h20,       32'hA5A5A5A5, 32'h0,        1'b0, 1};
    vt[17] = '{2, 1'b0, 32'h20,       32'h0,        32'hA5A5A5A5, 1'b0, 1};

    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   resp_ready[d] = 1'b0;
    end
    reset = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst d%0d req_ready", d), 32'(req_ready[d]), 32'h0);
      chk($sformatf("rst d%0d resp_valid", d), 32'(resp_valid[d]), 32'h0);
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post-rst d%0d req_ready", d), 32'(req_ready[d]), 32'h1);
      chk($sformatf("post-rst d%0d rdata", d), resp_rdata[d], 32'h0);
      chk($sformatf("post-rst d%0d err", d), 32'(resp_err[d]), 32'h0);
    end

    // Vector table
    for (int i = 0; i < 18; i++) begin
      txn(vt[i].d, vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("v%0d rdata", i), rd, vt[i].rdata);
      chk($sformatf("v%0d err", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("v%0d lat", i), 32'(lat), 32'(vt[i].lat));
    end

    // RESP held with resp_ready=0; a pulsed store must not be taken
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    waited = 0;
    while (!resp_valid[0] && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid[0] = (c == 2); req_we[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0;
      chk($sformatf("hold%0d resp_valid", c), 32'(resp_valid[0]), 32'h1);
      chk($sformatf("hold%0d rdata", c), resp_rdata[0], 32'hDEADBEEF);
      chk($sformatf("hold%0d err", c), 32'(resp_err[0]), 32'h0);
      chk($sformatf("hold%0d req_ready", c), 32'(req_ready[0]), 32'h0);
    end
    @(negedge clk);
    req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("hold release resp_valid", 32'(resp_valid[0]), 32'h0);
    chk("hold release rdata", resp_rdata[0], 32'h0);
    @(negedge clk);
    resp_ready[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold no stray resp", 32'(resp_valid[0]), 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("hold after-load rdata", rd, 32'hDEADBEEF);

    // Reset on the commit edge of a store
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rc resp_valid", 32'(resp_valid[0]), 32'h0);
    chk("rc req_ready d0", 32'(req_ready[0]), 32'h0);
    chk("rc req_ready d1", 32'(req_ready[1]), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rc req_ready after", 32'(req_ready[0]), 32'h1);
    txn(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rc load rdata", rd, 32'hA5A5A5A5);
    chk("rc load err", 32'(er), 32'h0);

    // Back-to-back loads at LATENCY=1 with resp_ready tied high
    @(negedge clk);
    resp_ready[2] = 1'b1;
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h20;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (req_ready[2]) acc_c.push_back(c);
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    resp_ready[2] = 1'b0;
    chk("b2b accept count", 32'(acc_c.size()), 32'd4);
    for (int k = 1; k < acc_c.size(); k++)
      chk($sformatf("b2b spacing %0d", k), 32'(acc_c[k] - acc_c[k-1]), 32'd3);
    #1;
    chk("b2b drained", 32'(resp_valid[2]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
